// File: rtl/gf_sbox_pkg.sv
// Shared arithmetic for the all-normal-basis S-box datapath.
// Tower: GF(2^8) over [d^16, d], GF(2^4) over [alpha^8, alpha^2],
// GF(2^2) over [Omega^2, Omega]. Every element is packed {high coef, low coef},
// and the high coefficient belongs to the "conjugate" basis element.
package gf_sbox_pkg;

    typedef logic [1:0] gf2_t;
    typedef logic [3:0] gf4_t;
    typedef logic [7:0] gf8_t;

    // Normal-basis unit: both coefficients set at every level.
    localparam gf8_t GF8_ONE = 8'hFF;
    localparam gf4_t GF4_ONE = 4'hF;

    // nu = N^2 * alpha^2 in the [alpha^8, alpha^2] basis (N = Omega^2).
    localparam gf4_t GF4_NU = 4'hE;

    // Pipeline depth for the default build (mid register present).
    localparam int PIPE_MID_DEFAULT = 1;
    localparam int LATENCY          = (PIPE_MID_DEFAULT != 0) ? 3 : 2;

    // GF(2^2) multiply in [Omega^2, Omega].
    function automatic gf2_t gf2_mul(input gf2_t x, input gf2_t y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Squaring in a normal basis is a coefficient swap.
    function automatic gf2_t gf2_sq(input gf2_t x);
        return {x[0], x[1]};
    endfunction

    // Multiply by N = Omega^2.
    function automatic gf2_t gf2_scl_n(input gf2_t x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    // GF(2^4) multiply in [alpha^8, alpha^2]; the shared term is scaled by N.
    function automatic gf4_t gf4_mul(input gf4_t x, input gf4_t y);
        gf2_t e;
        e = gf2_scl_n(gf2_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf2_mul(x[3:2], y[3:2]) ^ e, gf2_mul(x[1:0], y[1:0]) ^ e};
    endfunction

    // GF(2^4) square in [alpha^8, alpha^2].
    function automatic gf4_t gf4_sq(input gf4_t x);
        gf2_t t;
        t = gf2_scl_n(gf2_sq(x[3:2] ^ x[1:0]));
        return {gf2_sq(x[3:2]) ^ t, gf2_sq(x[1:0]) ^ t};
    endfunction

    // Square then scale by nu; constant multiply folds down to XORs.
    function automatic gf4_t gf4_sq_scl(input gf4_t x);
        return gf4_mul(gf4_sq(x), GF4_NU);
    endfunction

endpackage

// File: rtl/gf_inv_8_pipe_inv4.sv
// Combinational GF(2^4) inverse in the [alpha^8, alpha^2] normal basis.
// Works through GF(2^2), where inversion is just squaring. 0 maps to 0.
module gf_inv_4_nb
    import gf_sbox_pkg::*;
(
    input  logic [3:0] c_i,
    output logic [3:0] c_inv_o
);

    gf2_t g;
    gf2_t h;
    gf2_t e;
    gf2_t e_inv;

    // Norm-like term e, its inverse, then scale the swapped halves.
    always_comb begin
        g       = c_i[3:2];
        h       = c_i[1:0];
        e       = gf2_scl_n(gf2_sq(g ^ h)) ^ gf2_mul(g, h);
        e_inv   = gf2_sq(e);
        c_inv_o = {gf2_mul(e_inv, h), gf2_mul(e_inv, g)};
    end

endmodule

// File: rtl/gf_inv_8_pipe.sv
// Pipelined GF(2^8) inverter, normal basis [d^16, d], valid/ready on both sides.
// Stage 1 computes the GF(2^4) norm c, stage 2 inverts it (register optional via
// PIPE_MID), the output stage multiplies back. 0x00 falls out as 0x00.
// Optional: define GF_INV_8_ZERO_FLAG_EN to add out_zero, set when the source byte was 0.
module gf_inv_8_pipe
    import gf_sbox_pkg::*;
#(
    parameter int PIPE_MID = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
`ifdef GF_INV_8_ZERO_FLAG_EN
    ,
    output logic       out_zero
`endif
);

    // Stage 1 state
    logic s1_valid_q;
    gf4_t s1_a_q;
    gf4_t s1_b_q;
    gf4_t s1_c_q;
    gf4_t s1_c_d;

    // Output stage state
    logic out_valid_q;
    gf8_t out_data_q;
    gf8_t out_data_d;

    // Handshake chain
    logic ready_1;
    logic ready_2;
    logic ready_out;

    // Whatever feeds the output stage (stage-2 register or stage-1 bypass)
    logic mid_valid;
    gf4_t mid_a;
    gf4_t mid_b;
    gf4_t mid_cinv;
    gf4_t s2_cinv_d;

`ifdef GF_INV_8_ZERO_FLAG_EN
    logic s1_zero_q;
    logic mid_zero;
    logic out_zero_q;
`endif

    assign ready_out = !out_valid_q || out_ready;
    assign ready_1   = !s1_valid_q || ready_2;
    assign in_ready  = ready_1;

    // Stage 1 norm: c = nu*(a+b)^2 + a*b
    always_comb begin
        s1_c_d = gf4_sq_scl(in_data[7:4] ^ in_data[3:0]) ^ gf4_mul(in_data[7:4], in_data[3:0]);
    end

    // Stage 1 register: load on accept, hold data when no valid input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
        end else if (ready_1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q <= in_data[7:4];
                s1_b_q <= in_data[3:0];
                s1_c_q <= s1_c_d;
            end
        end
    end

`ifdef GF_INV_8_ZERO_FLAG_EN
    // Stage 1 zero flag travels with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_zero_q <= 1'b0;
        end else if (ready_1 && in_valid) begin
            s1_zero_q <= (in_data == 8'h00);
        end
    end
`endif

    gf_inv_4_nb u_inv4 (
        .c_i     (s1_c_q),
        .c_inv_o (s2_cinv_d)
    );

    generate
        if (PIPE_MID != 0) begin : g_mid
            logic s2_valid_q;
            gf4_t s2_a_q;
            gf4_t s2_b_q;
            gf4_t s2_cinv_q;

            assign ready_2 = !s2_valid_q || ready_out;

            // Stage 2 register breaks the inversion -> multiply path
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_a_q     <= '0;
                    s2_b_q     <= '0;
                    s2_cinv_q  <= '0;
                end else if (ready_2) begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_a_q    <= s1_a_q;
                        s2_b_q    <= s1_b_q;
                        s2_cinv_q <= s2_cinv_d;
                    end
                end
            end

`ifdef GF_INV_8_ZERO_FLAG_EN
            logic s2_zero_q;

            // Stage 2 zero flag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_zero_q <= 1'b0;
                end else if (ready_2 && s1_valid_q) begin
                    s2_zero_q <= s1_zero_q;
                end
            end

            assign mid_zero = s2_zero_q;
`endif

            assign mid_valid = s2_valid_q;
            assign mid_a     = s2_a_q;
            assign mid_b     = s2_b_q;
            assign mid_cinv  = s2_cinv_q;
        end else begin : g_nomid
            assign ready_2   = ready_out;
            assign mid_valid = s1_valid_q;
            assign mid_a     = s1_a_q;
            assign mid_b     = s1_b_q;
            assign mid_cinv  = s2_cinv_d;
`ifdef GF_INV_8_ZERO_FLAG_EN
            assign mid_zero  = s1_zero_q;
`endif
        end
    endgenerate

    // Output multiply: the halves swap because the normal-basis inverse pairs c^-1*b with d^16
    always_comb begin
        out_data_d = {gf4_mul(mid_cinv, mid_b), gf4_mul(mid_cinv, mid_a)};
    end

    // Output register: holds while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (ready_out) begin
            out_valid_q <= mid_valid;
            if (mid_valid) begin
                out_data_q <= out_data_d;
            end
        end
    end

`ifdef GF_INV_8_ZERO_FLAG_EN
    // Output zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero_q <= 1'b0;
        end else if (ready_out && mid_valid) begin
            out_zero_q <= mid_zero;
        end
    end

    assign out_zero = out_zero_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf_inv_8_pipe.sv
// Self-checking bench for gf_inv_8_pipe. The reference computes x^254 with a
// plain normal-basis field multiply; a scoreboard queue decouples stimulus from
// the output monitor. Define GF_INV_8_ZERO_FLAG_EN to also check out_zero.
module tb_gf_inv_8_pipe;

    parameter int PIPE_MID = 1;
    // Edges from the accepting edge (counted as the first) until out_valid shows.
    localparam int LAT = (PIPE_MID != 0) ? 3 : 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] in_data   = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef GF_INV_8_ZERO_FLAG_EN
    logic       out_zero;
`endif

    gf_inv_8_pipe #(.PIPE_MID(PIPE_MID)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef GF_INV_8_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- reference field arithmetic ----------------
    function automatic logic [1:0] m_mul2(input logic [1:0] x, input logic [1:0] y);
        // basis [W^2, W], W^2 = W + 1
        logic s;
        s = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ s, (x[0] & y[0]) ^ s};
    endfunction

    function automatic logic [3:0] m_mul4(input logic [3:0] x, input logic [3:0] y);
        // basis [Z^4, Z], Z^2 + Z + N = 0, N = W^2 = 2'b10
        logic [1:0] s;
        s = m_mul2(2'b10, m_mul2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {m_mul2(x[3:2], y[3:2]) ^ s, m_mul2(x[1:0], y[1:0]) ^ s};
    endfunction

    function automatic logic [7:0] m_mul8(input logic [7:0] x, input logic [7:0] y);
        // basis [D^16, D], D^2 + D + nu = 0, nu = N^2 * Z^2 = 4'hE
        logic [3:0] s;
        s = m_mul4(4'hE, m_mul4(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]));
        return {m_mul4(x[7:4], y[7:4]) ^ s, m_mul4(x[3:0], y[3:0]) ^ s};
    endfunction

    // Inverse as x^254 (x^255 = 1 for nonzero x); yields 0 for 0.
    function automatic logic [7:0] m_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] ex;
        r  = 8'hFF;
        p  = x;
        ex = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (ex[i]) r = m_mul8(r, p);
            p = m_mul8(p, p);
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] out_log[$];
    bit         log_en = 1'b0;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    exp_t       acc_e;
    exp_t       mon_e;

    function automatic void chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Record every accepted input with its expected response.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            acc_e.x = in_data;
            acc_e.y = m_inv(in_data);
            acc_e.z = (in_data == 8'h00);
            sb.push_back(acc_e);
        end
    end

    // Compare every output transfer against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("out_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out_data", int'(out_data), int'(mon_e.y));
                if (mon_e.x != 8'h00) chk("mul_to_one", int'(m_mul8(mon_e.x, out_data)), 8'hFF);
`ifdef GF_INV_8_ZERO_FLAG_EN
                chk("out_zero", int'(out_zero), int'(mon_e.z));
`endif
                if (log_en) out_log.push_back(out_data);
                $display("xfer in=%02h out=%02h", mon_e.x, out_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int   tries;
        logic acc;
        tries    = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            tries++;
        end
        chk("send_accepted", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic latency_test(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, LAT);
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 3) tick();
        chk(name, sb.size(), 0);
    endtask

    // Hard stop if something wedges the run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] fb[$];
        logic [7:0] held;
        int         cyc_start;
        int         n;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_in_ready",  int'(in_ready),  1);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("idle_out_valid", int'(out_valid), 0);

        // First results and latency
        latency_test(8'h00);
        latency_test(8'hFF);
        latency_test(8'h01);

        // Full sweep, back to back
        log_en    = 1'b1;
        cyc_start = cyc;
        for (int i = 0; i < 256; i++) send(i[7:0]);
        chk("sweep_cycles", cyc - cyc_start, 256);
        drain("sweep_drained");
        chk("sweep_count", out_log.size(), 256);

        // Feed every result back; must return the original byte
        fb = out_log;
        out_log.delete();
        for (int i = 0; i < fb.size(); i++) send(fb[i]);
        drain("feedback_drained");
        chk("feedback_count", out_log.size(), 256);
        for (int i = 0; i < out_log.size() && i < 256; i++) chk("roundtrip", int'(out_log[i]), i);
        log_en = 1'b0;

        // Backpressure: fill the pipe and stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            in_data = 8'($urandom);
            tick();
        end
        @(negedge clk);
        chk("bp_in_ready_full", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_items_held", sb.size(), LAT);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("bp_out_stable", int'(out_data), int'(held));
            chk("bp_in_ready_low", int'(in_ready), 0);
        end
        // Release while still offering input: full pipe must shift with no bubble
        tick();
        out_ready = 1'b1;
        in_data   = 8'($urandom);
        @(negedge clk);
        chk("full_shift_ready", int'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            in_data = 8'($urandom);
        end
        drain("bp_drained");

        // Asynchronous reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        tick();
        in_data   = 8'($urandom);
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ar_out_valid_before", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("ar_out_valid_async", int'(out_valid), 0);
        chk("ar_out_data_async", int'(out_data), 0);
        chk("ar_in_ready_async", int'(in_ready), 1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("ar_no_stale", int'(out_valid), 0);

        // Randomized valid/ready traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = (c % 7 == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand_drained");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
